// File: rtl/apple_gen_if.sv
// Game-side signal bundle for the apple generator.
// The master side (game logic / VGA scan) drives the play state, the snake head and the pixel position.
// The slave side (apple_gen) returns the grow request, the apple cell, the pixel hit and the score.
interface apple_gen_if;
  logic       s_play;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       add_cube;
  logic [5:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_pix;
  logic [7:0] score;

  modport master (
    output s_play, head_x, head_y, x_pos, y_pos,
    input  add_cube, apple_x, apple_y, apple_pix, score
  );

  modport slave (
    input  s_play, head_x, head_y, x_pos, y_pos,
    output add_cube, apple_x, apple_y, apple_pix, score
  );
endinterface

// File: rtl/apple_gen.sv
// Apple generator for the snake game: places apples with a free-running LFSR,
// detects the head eating them, pulses add_cube and keeps the score.
// Optional feature: define APPLE_RELOCATE_EN to move an uneaten apple after
// RELOCATE_CYCLES clk cycles in WAIT; without it the apple waits forever.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | game not in play; apple, score held, apple visible
// ST_WAIT  | apple placed and visible, waiting for the head to reach it
// ST_EAT   | apple eaten; add_cube held high for ADD_HOLD cycles
// ST_PLACE | drawing LFSR candidates until one lands on a legal free cell
module apple_gen #(
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          ADD_HOLD        = 4,
  parameter int          RELOCATE_CYCLES = 500000000
) (
  input logic        clk,
  input logic        clr,
  apple_gen_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EAT, ST_PLACE} state_t;

  // Parameter sanity: hold counter is 4 bits, timeout counter 29 bits, LFSR must not lock at zero.
  if (ADD_HOLD < 2 || ADD_HOLD > 15) begin : g_bad_hold
    $error("apple_gen: ADD_HOLD must be within 2..15");
  end
  if (RELOCATE_CYCLES < 1 || RELOCATE_CYCLES > 536870912) begin : g_bad_reloc
    $error("apple_gen: RELOCATE_CYCLES must fit the 29-bit timeout counter");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("apple_gen: LFSR_SEED must be nonzero");
  end

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [3:0]  r_hold;
  logic [5:0]  r_apple_x;
  logic [5:0]  r_apple_y;
  logic [7:0]  r_score;
  logic        r_add_cube;
  logic [5:0]  w_cx;
  logic [5:0]  w_cy;
  logic        w_cand_ok;
  logic        w_hit;
  logic        w_tmo_done;
  logic        w_eat_start;

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  // Candidate cell comes straight from the current LFSR value; y is limited to 5 bits.
  assign w_cx      = r_lfsr[5:0];
  assign w_cy      = {1'b0, r_lfsr[12:8]};
  assign w_cand_ok = (w_cx >= 6'd1) && (w_cx <= 6'd38) &&
                     (w_cy >= 6'd1) && (w_cy <= 6'd28) &&
                     !((w_cx == bus.head_x) && (w_cy == bus.head_y));
  assign w_hit     = (bus.head_x == r_apple_x) && (bus.head_y == r_apple_y);

`ifdef APPLE_RELOCATE_EN
  logic [28:0] r_tmo;

  assign w_tmo_done = (r_tmo == 29'(RELOCATE_CYCLES - 1));

  // Idle-apple timer: restarts on every WAIT entry, counts while waiting.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_tmo <= '0;
    else if ((w_next == ST_WAIT) && (r_state != ST_WAIT))
      r_tmo <= '0;
    else if (r_state == ST_WAIT)
      r_tmo <= r_tmo + 29'd1;
  end
`else
  assign w_tmo_done = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; leaving play overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.s_play) w_next = ST_WAIT;
      ST_WAIT:  begin
        if (w_hit)
          w_next = ST_EAT;
        else if (w_tmo_done)
          w_next = ST_PLACE;
      end
      ST_EAT:   if (r_hold == 4'd0) w_next = ST_PLACE;
      ST_PLACE: if (w_cand_ok) w_next = ST_WAIT;
      default:  w_next = ST_IDLE;
    endcase
    if (!bus.s_play)
      w_next = ST_IDLE;
  end

  assign w_eat_start = (r_state == ST_WAIT) && (w_next == ST_EAT);

  // LFSR free-runs in every state so placement varies with play timing.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_lfsr <= LFSR_SEED;
    else
      r_lfsr <= w_lfsr_next;
  end

  // Hold down-counter: loaded on EAT entry, EAT ends when it reaches zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_hold <= 4'd0;
    else if (w_eat_start)
      r_hold <= 4'(ADD_HOLD - 1);
    else if ((r_state == ST_EAT) && (r_hold != 4'd0))
      r_hold <= r_hold - 4'd1;
  end

  // Grow request registered from the next state so it is high exactly while in EAT.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_add_cube <= 1'b0;
    else
      r_add_cube <= (w_next == ST_EAT);
  end

  // Score counts eat events and sticks at 255.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      r_score <= 8'd0;
    else if (w_eat_start && (r_score != 8'hFF))
      r_score <= r_score + 8'd1;
  end

  // Apple cell loads only when a candidate is accepted in PLACE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_apple_x <= 6'd20;
      r_apple_y <= 6'd15;
    end else if ((r_state == ST_PLACE) && (w_next == ST_WAIT)) begin
      r_apple_x <= w_cx;
      r_apple_y <= w_cy;
    end
  end

  assign bus.add_cube  = r_add_cube;
  assign bus.apple_x   = r_apple_x;
  assign bus.apple_y   = r_apple_y;
  assign bus.score     = r_score;
  assign bus.apple_pix = (bus.x_pos < 10'd640) && (bus.y_pos < 10'd480) &&
                         (bus.x_pos[9:4] == r_apple_x) && (bus.y_pos[9:4] == r_apple_y) &&
                         ((r_state == ST_IDLE) || (r_state == ST_WAIT));

endmodule

// File: doc/apple_gen.md
APPLE_GEN -- requirements
Module: apple_gen

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, the nonzero reset value of the LFSR.
REQ-002 SHALL have parameter ADD_HOLD, default 4, the number of cycles add_cube is held high per eat event (range 2..15).
REQ-003 SHALL have parameter RELOCATE_CYCLES, default 500000000, the idle-apple timeout in clk cycles (used only under REQ-027).
REQ-004 SHALL have port clk, input, 1, the system clock; all state is updated on its rising edge.
REQ-005 SHALL have port clr, input, 1, the reset: asynchronous, active-high.
REQ-006 SHALL have port s_play, input, 1, high while the game is in the play state.
REQ-007 SHALL have ports head_x and head_y, input, 6 each, the snake head cell coordinates.
REQ-008 SHALL have ports x_pos and y_pos, input, 10 each, the current VGA pixel position.
REQ-009 SHALL have port add_cube, output reg, 1, the grow request to the snake block.
REQ-010 SHALL have ports apple_x and apple_y, output reg, 6 each, the apple cell coordinates.
REQ-011 SHALL have port apple_pix, output, 1, high when the current pixel lies in the apple cell.
REQ-012 SHALL have port score, output reg, 8, the count of apples eaten.

Function
REQ-013 SHALL implement a 16-bit Galois LFSR with polynomial mask 16'hB400 that advances every clk cycle in every state.
REQ-014 SHALL implement FSM states IDLE, WAIT, EAT and PLACE.
REQ-015 SHALL take IDLE->WAIT in the cycle after s_play is sampled high in IDLE.
REQ-016 SHALL take any state->IDLE in the next cycle when s_play is sampled low, drive add_cube=0, and retain apple_x, apple_y and score; this rule has priority over every other transition.
REQ-017 SHALL, in WAIT when head_x==apple_x and head_y==apple_y in cycle N, enter EAT with add_cube=1 and score incremented in cycle N+1.
REQ-018 SHALL hold add_cube=1 for exactly ADD_HOLD cycles in EAT, then enter PLACE with add_cube=0.
REQ-019 SHALL saturate score at 255 and not wrap.
REQ-020 SHALL, in PLACE each cycle, form the candidate cx=lfsr[5:0] and cy={1'b0,lfsr[12:8]}.
REQ-021 SHALL accept the candidate only if 1<=cx<=38, 1<=cy<=28 and (cx,cy)!=(head_x,head_y); on acceptance it SHALL load apple_x/apple_y and enter WAIT in the next cycle, otherwise retry with the next LFSR value.
REQ-022 SHALL drive apple_pix = (x_pos<640)&&(y_pos<480)&&(x_pos[9:4]==apple_x)&&(y_pos[9:4]==apple_y)&&(state is IDLE or WAIT), combinationally.
REQ-023 SHALL keep add_cube low in IDLE, WAIT and PLACE.

Reset
REQ-024 SHALL, on clr, force state=IDLE, lfsr=LFSR_SEED, apple_x=20, apple_y=15, score=0, add_cube=0 and the timeout counter=0.
REQ-025 SHALL let clr asserted mid-EAT drop add_cube immediately (asynchronously), with no score change after reset.

Configuration
REQ-026 SHALL use the macro APPLE_RELOCATE_EN to select the timeout feature.
REQ-027 SHALL, with APPLE_RELOCATE_EN defined, clear a 29-bit counter on WAIT entry, count it each WAIT cycle, and on reaching RELOCATE_CYCLES-1 enter PLACE with no add_cube pulse and no score change; a head match in the same cycle takes priority (EAT).
REQ-028 SHALL, without APPLE_RELOCATE_EN, omit the counter and keep the apple in WAIT indefinitely.

Verification
REQ-029 SHALL cover: clr pulse -> apple=(20,15), score=0, add_cube=0, state IDLE; then s_play=1 -> WAIT after 1 cycle.
REQ-030 SHALL cover: head=(20,15) in WAIT -> add_cube high exactly 4 cycles starting the next cycle, score=1, then a new apple within 1..38 x 1..28, not equal to the head.
REQ-031 SHALL cover: s_play dropped during the 2nd cycle of EAT -> add_cube=0 next cycle, IDLE, score kept at 1.
REQ-032 SHALL cover: 300 forced eats -> score stays 255, and every placed apple lies within bounds.
REQ-033 SHALL cover: x_pos=320..335, y_pos=240..255 with apple (20,15) -> apple_pix=1; x_pos=336 -> 0; x_pos=700 -> 0.
REQ-034 SHALL cover, with APPLE_RELOCATE_EN and RELOCATE_CYCLES=100: no head match -> PLACE entered 100 cycles after WAIT entry, score unchanged, add_cube never high.
